dram_arbiter: RTL and testbench
===============================

Name: dram_arbiter

Overview:
- Two-master arbiter that shares the single-port data RAM between the CPU core's load/store port and a debug/DMA port.
  - The debug/DMA port is used by switch-driven test loaders and memory dumpers.
- Sits between the core's `ram_*` outputs and the data RAM instance, clocked by the same divided clock as the core.
- The core has default priority. An anti-starvation counter and a bounded lock mode guarantee forward progress for both masters.

Parameters:
- DW, 32, data width (matches the register bus)
- AW, 32, address width (matches the register bus)
- MAX_WAIT, 8, consecutive denied debug-request cycles before the debug port is force-granted
- LOCK_MAX, 16, maximum consecutive debug-owned cycles in lock mode

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low
- core_ce_i  in  1  core memory access request
- core_we_i  in  1  core write enable
- core_addr_i  in  AW  core address
- core_data_i  in  DW  core write data
- core_data_o  out  DW  core read data
- core_stall_o  out  1  core must hold its access and retry next cycle
- dbg_req_i  in  1  debug access request
- dbg_lock_i  in  1  debug requests back-to-back ownership
- dbg_we_i  in  1  debug write enable
- dbg_addr_i  in  AW  debug address
- dbg_data_i  in  DW  debug write data
- dbg_gnt_o  out  1  debug access performed this cycle
- dbg_rdata_o  out  DW  registered debug read data
- dbg_rvalid_o  out  1  dbg_rdata_o valid (one-cycle pulse)
- ram_ce_o, ram_we_o  out  1 each  to RAM
- ram_addr_o  out  AW  to RAM
- ram_data_o  out  DW  to RAM
- ram_data_i  in  DW  RAM read data (combinational read, write on clk rising edge)

Behaviour:
- States:
  - S_CORE: default.
  - S_DBG: debug locked.
  - S_COOL: one-cycle core-only window.
- Registers:
  - state, reset S_CORE.
  - wait_cnt (clog2(MAX_WAIT+1) bits), reset 0.
  - lock_cnt (clog2(LOCK_MAX+1) bits), reset 0.
  - dbg_rdata_o, reset 0.
  - dbg_rvalid_o, reset 0.
- Combinational grant: dbg_win = dbg_req_i & ((state==S_CORE & (!core_ce_i | wait_cnt==MAX_WAIT)) | state==S_DBG).
  - In S_COOL, dbg_win = 0.
- RAM mux:
  - If dbg_win, ram_* are driven from dbg_*; ram_ce_o = 1.
  - Otherwise ram_* are driven from core_*.
- Outputs:
  - dbg_gnt_o = dbg_win.
  - core_stall_o = core_ce_i & dbg_win.
  - core_data_o = ram_data_i when !dbg_win, else 0.
  - With rst low, every RAM control is 0, core_stall_o = 0 and dbg_gnt_o = 0.
- wait_cnt:
  - Increments, saturating at MAX_WAIT, each cycle dbg_req_i is 1 and dbg_win is 0.
  - Clears on any dbg_win or when dbg_req_i is 0.
- Read return: on each cycle with dbg_win & !dbg_we_i, capture ram_data_i into dbg_rdata_o and pulse dbg_rvalid_o the next cycle. Writes give no rvalid.
- Transitions:
  - S_CORE -> S_DBG when dbg_win & dbg_lock_i; lock_cnt := 1.
  - S_DBG stays while dbg_req_i & dbg_lock_i & lock_cnt < LOCK_MAX; lock_cnt increments on each granted cycle.
  - S_DBG -> S_COOL when lock_cnt == LOCK_MAX and a request is still pending.
  - S_DBG -> S_CORE when dbg_req_i or dbg_lock_i drops.
  - S_COOL -> S_CORE unconditionally after one cycle.
- In S_DBG the core is stalled whenever core_ce_i is 1. The core's first access after the lock ends is served in S_COOL, or in S_CORE if the lock dropped early.
- Simultaneous events:
  - Core idle with a debug request: debug is granted with zero wait.
  - Both requesting: the core wins until the starvation threshold.
  - A forced grant stalls the core exactly one cycle unless lock is asserted.
- Asynchronous reset mid-lock returns to S_CORE immediately and clears the counters. A debug read in flight is dropped (no rvalid).

Decomposition:
- Shared defines file holds:
  - State encodings: S_CORE=2'b00, S_DBG=2'b01, S_COOL=2'b10.
  - Enable and disable constants.
- Bus widths come from the existing register-bus and address-bus defines.
- One natural sub-module: dram_arb_starve_cnt (saturating wait counter with threshold flag).

Test Plan:
1. Reset released, core issues write 0x0000_0010 <- 0xDEAD_BEEF, no debug request -> RAM sees the write the same cycle; core_stall_o=0; dbg_gnt_o=0.
2. Core idle, debug read at 0x10 -> dbg_gnt_o=1 that cycle; next cycle dbg_rvalid_o=1 and dbg_rdata_o=0xDEAD_BEEF.
3. core_ce_i held 1 continuously, dbg_req_i held 1 -> wait_cnt reaches 8; debug granted on the 9th cycle with core_stall_o=1 for exactly that cycle, then the core resumes.
4. Core idle, debug lock mode writing 20 words -> granted 16 consecutive cycles; S_COOL for one cycle with dbg_gnt_o=0; then the remaining 4 are granted.
5. Core accessing during debug lock -> core_stall_o=1 every lock cycle; the core access completes in the S_COOL cycle.
6. rst asserted low in the middle of S_DBG with a read granted -> all outputs drop to reset values asynchronously; no dbg_rvalid_o after release; state is S_CORE.

Source files
------------

// File: rtl/dram_arbiter_pkg.sv
// ============================================================================
// Module : dram_arbiter_pkg
// Purpose: Shared definitions for the data-RAM arbiter.
//          - Arbiter state encodings.
//          - Enable/disable constants.
//          - Default bus widths taken from the register and address buses.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package dram_arbiter_pkg;

    // Default widths, shared with the register bus and the address bus
    localparam int REG_BUS_W  = 32;
    localparam int ADDR_BUS_W = 32;

    localparam logic EN  = 1'b1;
    localparam logic DIS = 1'b0;

    typedef enum logic [1:0] {
        S_CORE = 2'b00,   // core owns the RAM by default
        S_DBG  = 2'b01,   // debug port holds a bounded lock
        S_COOL = 2'b10    // one-cycle core-only window after a full lock
    } arb_state_e;

endpackage : dram_arbiter_pkg

`default_nettype wire

// File: rtl/dram_arb_starve_cnt.sv
// ============================================================================
// Module : dram_arb_starve_cnt
// Purpose: Saturating count of consecutive denied debug-request cycles.
//          at_max flags that the debug port is due a forced grant.
// Ports  : clk, rst (async, active-low)
//          req     - debug request is pending this cycle
//          win     - debug request was granted this cycle
//          at_max  - count has saturated at MAX
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dram_arb_starve_cnt
    import dram_arbiter_pkg::*;
#(
    parameter int MAX = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic win,
    output logic at_max
);

    localparam int            CW    = $clog2(MAX + 1);
    localparam logic [CW-1:0] MAX_C = CW'(MAX);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (!req || win) begin
            // Any grant, or the request going away, restarts the starvation window
            count <= '0;
        end else if (count != MAX_C) begin
            count <= count + 1'b1;
        end
    end

    assign at_max = (count == MAX_C) ? EN : DIS;

endmodule : dram_arb_starve_cnt

`default_nettype wire

// File: rtl/dram_arbiter.sv
// ============================================================================
// Module : dram_arbiter
// Purpose: Shares the single-port data RAM between the core load/store port
//          and the debug/DMA port. The core has default priority; a
//          starvation counter forces a debug grant after MAX_WAIT denied
//          cycles, and a lock mode gives debug up to LOCK_MAX back-to-back
//          cycles, followed by a one-cycle core-only window.
// Ports  : clk, rst (async, active-low)
//          core_*  - core side: request, stall and combinational read data
//          dbg_*   - debug side: request/lock, grant, registered read return
//          ram_*   - to/from the RAM (combinational read, write on clk rise)
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dram_arbiter
    import dram_arbiter_pkg::*;
#(
    parameter int DW       = REG_BUS_W,
    parameter int AW       = ADDR_BUS_W,
    parameter int MAX_WAIT = 8,
    parameter int LOCK_MAX = 16
) (
    input  logic          clk,
    input  logic          rst,
    // core port
    input  logic          core_ce_i,
    input  logic          core_we_i,
    input  logic [AW-1:0] core_addr_i,
    input  logic [DW-1:0] core_data_i,
    output logic [DW-1:0] core_data_o,
    output logic          core_stall_o,
    // debug port
    input  logic          dbg_req_i,
    input  logic          dbg_lock_i,
    input  logic          dbg_we_i,
    input  logic [AW-1:0] dbg_addr_i,
    input  logic [DW-1:0] dbg_data_i,
    output logic          dbg_gnt_o,
    output logic [DW-1:0] dbg_rdata_o,
    output logic          dbg_rvalid_o,
    // RAM port
    output logic          ram_ce_o,
    output logic          ram_we_o,
    output logic [AW-1:0] ram_addr_o,
    output logic [DW-1:0] ram_data_o,
    input  logic [DW-1:0] ram_data_i
);

    localparam int            LW     = $clog2(LOCK_MAX + 1);
    localparam logic [LW-1:0] LOCK_C = LW'(LOCK_MAX);
    localparam logic [LW-1:0] ONE_C  = LW'(1);

    arb_state_e    state, state_nxt;
    logic [LW-1:0] lock_cnt, lock_nxt, lock_inc;
    logic          wait_full;
    logic          dbg_win;

    dram_arb_starve_cnt #(
        .MAX    (MAX_WAIT)
    ) u_starve_cnt (
        .clk    (clk),
        .rst    (rst),
        .req    (dbg_req_i),
        .win    (dbg_win),
        .at_max (wait_full)
    );

    // ------------------------------------------------------------------
    // State register and debug read return
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_CORE;
            lock_cnt     <= '0;
            dbg_rdata_o  <= '0;
            dbg_rvalid_o <= DIS;
        end else begin
            state        <= state_nxt;
            lock_cnt     <= lock_nxt;
            dbg_rvalid_o <= dbg_win & ~dbg_we_i;
            if (dbg_win && !dbg_we_i) begin
                dbg_rdata_o <= ram_data_i;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. lock_cnt counts granted lock cycles including the
    // current one, so the lock ends after exactly LOCK_MAX grants.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        lock_nxt  = lock_cnt;
        lock_inc  = lock_cnt + 1'b1;
        case (state)
            S_CORE: begin
                if (dbg_win && dbg_lock_i) begin
                    if (ONE_C >= LOCK_C) begin
                        state_nxt = S_COOL;
                        lock_nxt  = '0;
                    end else begin
                        state_nxt = S_DBG;
                        lock_nxt  = ONE_C;
                    end
                end
            end
            S_DBG: begin
                if (!(dbg_req_i && dbg_lock_i)) begin
                    state_nxt = S_CORE;
                    lock_nxt  = '0;
                end else if (lock_inc >= LOCK_C) begin
                    state_nxt = S_COOL;
                    lock_nxt  = '0;
                end else begin
                    lock_nxt  = lock_inc;
                end
            end
            S_COOL: begin
                state_nxt = S_CORE;
                lock_nxt  = '0;
            end
            default: begin
                state_nxt = S_CORE;
                lock_nxt  = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Grant and RAM mux. Everything that can start a RAM cycle or stall
    // the core is gated by rst so the outputs fall the moment reset lands.
    // ------------------------------------------------------------------
    always_comb begin
        dbg_win = DIS;
        if (rst && dbg_req_i) begin
            case (state)
                S_CORE:  dbg_win = !core_ce_i || wait_full;
                S_DBG:   dbg_win = EN;
                default: dbg_win = DIS;
            endcase
        end

        if (dbg_win) begin
            ram_ce_o   = EN;
            ram_we_o   = dbg_we_i;
            ram_addr_o = dbg_addr_i;
            ram_data_o = dbg_data_i;
        end else begin
            ram_ce_o   = core_ce_i & rst;
            ram_we_o   = core_we_i & rst;
            ram_addr_o = core_addr_i;
            ram_data_o = core_data_i;
        end

        dbg_gnt_o    = dbg_win;
        core_stall_o = core_ce_i & dbg_win;
        core_data_o  = dbg_win ? '0 : ram_data_i;
    end

endmodule : dram_arbiter

`default_nettype wire

// File: tb/tb_dram_arbiter.sv
// ============================================================================
// Module : tb_dram_arbiter
// Purpose: Directed self-checking bench for dram_arbiter with a small
//          behavioural RAM (combinational read, write on clk rise).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dram_arbiter;
    import dram_arbiter_pkg::*;

    logic        clk;
    logic        rst;
    logic        core_ce, core_we;
    logic [31:0] core_addr, core_wdata, core_rdata;
    logic        core_stall;
    logic        dbg_req, dbg_lock, dbg_we;
    logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
    logic        dbg_gnt, dbg_rvalid;
    logic        ram_ce, ram_we;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [0:255];

    dram_arbiter #(
        .DW (32), .AW (32), .MAX_WAIT (8), .LOCK_MAX (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .core_ce_i    (core_ce),
        .core_we_i    (core_we),
        .core_addr_i  (core_addr),
        .core_data_i  (core_wdata),
        .core_data_o  (core_rdata),
        .core_stall_o (core_stall),
        .dbg_req_i    (dbg_req),
        .dbg_lock_i   (dbg_lock),
        .dbg_we_i     (dbg_we),
        .dbg_addr_i   (dbg_addr),
        .dbg_data_i   (dbg_wdata),
        .dbg_gnt_o    (dbg_gnt),
        .dbg_rdata_o  (dbg_rdata),
        .dbg_rvalid_o (dbg_rvalid),
        .ram_ce_o     (ram_ce),
        .ram_we_o     (ram_we),
        .ram_addr_o   (ram_addr),
        .ram_data_o   (ram_wdata),
        .ram_data_i   (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM
    assign ram_rdata = mem[ram_addr[9:2]];
    always @(posedge clk) begin
        if (ram_ce && ram_we) mem[ram_addr[9:2]] <= ram_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; checks run 1 ns later.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        core_ce = 0; core_we = 0; core_addr = '0; core_wdata = '0;
        dbg_req = 0; dbg_lock = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        rst = 0;
        idle_inputs();
        // Requests active during reset must not reach the RAM
        core_ce = 1; core_we = 1; dbg_req = 1;
        #1;
        chk("rst_ram_ce", {31'b0, ram_ce}, 32'd0);
        chk("rst_ram_we", {31'b0, ram_we}, 32'd0);
        chk("rst_stall", {31'b0, core_stall}, 32'd0);
        chk("rst_gnt", {31'b0, dbg_gnt}, 32'd0);
        chk("rst_rvalid", {31'b0, dbg_rvalid}, 32'd0);
        chk("rst_rdata", dbg_rdata, 32'd0);
        @(negedge clk);
        @(negedge clk);
        idle_inputs();
        rst = 1;

        // ---- 1: core write, no debug ----
        tick();
        core_ce = 1; core_we = 1; core_addr = 32'h10; core_wdata = 32'hDEAD_BEEF;
        #1;
        chk("t1_ram_ce", {31'b0, ram_ce}, 32'd1);
        chk("t1_ram_we", {31'b0, ram_we}, 32'd1);
        chk("t1_ram_addr", ram_addr, 32'h10);
        chk("t1_ram_data", ram_wdata, 32'hDEAD_BEEF);
        chk("t1_stall", {31'b0, core_stall}, 32'd0);
        chk("t1_gnt", {31'b0, dbg_gnt}, 32'd0);
        tick();
        core_we = 0;
        #1;
        chk("t1_core_rd", core_rdata, 32'hDEAD_BEEF);

        // ---- 2: core idle, debug read ----
        tick();
        idle_inputs();
        dbg_req = 1; dbg_addr = 32'h10;
        #1;
        chk("t2_gnt", {31'b0, dbg_gnt}, 32'd1);
        chk("t2_ram_addr", ram_addr, 32'h10);
        chk("t2_core_data0", core_rdata, 32'd0);
        tick();
        dbg_req = 0;
        chk("t2_rvalid", {31'b0, dbg_rvalid}, 32'd1);
        chk("t2_rdata", dbg_rdata, 32'hDEAD_BEEF);
        tick();
        chk("t2_rvalid_pulse", {31'b0, dbg_rvalid}, 32'd0);

        // ---- 3: starvation forces a grant on the 9th cycle ----
        core_ce = 1; core_we = 0; core_addr = 32'h20;
        dbg_req = 1; dbg_addr = 32'h10;
        #1;
        for (int c = 0; c < 8; c++) begin
            chk($sformatf("t3_deny_gnt_%0d", c), {31'b0, dbg_gnt}, 32'd0);
            chk($sformatf("t3_deny_stall_%0d", c), {31'b0, core_stall}, 32'd0);
            tick();
        end
        chk("t3_force_gnt", {31'b0, dbg_gnt}, 32'd1);
        chk("t3_force_stall", {31'b0, core_stall}, 32'd1);
        chk("t3_force_addr", ram_addr, 32'h10);
        tick();
        chk("t3_resume_gnt", {31'b0, dbg_gnt}, 32'd0);
        chk("t3_resume_stall", {31'b0, core_stall}, 32'd0);
        chk("t3_resume_addr", ram_addr, 32'h20);
        chk("t3_rvalid", {31'b0, dbg_rvalid}, 32'd1);
        chk("t3_rdata", dbg_rdata, 32'hDEAD_BEEF);
        tick();
        idle_inputs();

        // ---- 4: lock mode, 20 writes: 16 grants, cool gap, then 4 ----
        begin
            int word;
            word = 0;
            dbg_req = 1; dbg_lock = 1; dbg_we = 1;
            for (int c = 0; c < 21; c++) begin
                dbg_addr = 32'h100 + 32'(word * 4);
                dbg_wdata = 32'(word);
                #1;
                chk($sformatf("t4_gnt_c%0d", c), {31'b0, dbg_gnt}, (c == 16) ? 32'd0 : 32'd1);
                if (dbg_gnt) word++;
                tick();
            end
            chk("t4_rvalid_wr", {31'b0, dbg_rvalid}, 32'd0);
            idle_inputs();
            tick();
            chk("t4_mem_w0", mem[8'h40], 32'd0);
            chk("t4_mem_w15", mem[8'h4F], 32'd15);
            chk("t4_mem_w16", mem[8'h50], 32'd16);
            chk("t4_mem_w19", mem[8'h53], 32'd19);
        end

        // ---- 5: core access stalls through the lock, served in cool ----
        dbg_req = 1; dbg_lock = 1; dbg_we = 0; dbg_addr = 32'h100;
        #1;
        chk("t5_entry_gnt", {31'b0, dbg_gnt}, 32'd1);
        tick();
        core_ce = 1; core_we = 1; core_addr = 32'h200; core_wdata = 32'hCAFE_0005;
        for (int c = 1; c < 16; c++) begin
            #1;
            chk($sformatf("t5_lock_stall_%0d", c), {31'b0, core_stall}, 32'd1);
            chk($sformatf("t5_lock_gnt_%0d", c), {31'b0, dbg_gnt}, 32'd1);
            tick();
        end
        chk("t5_cool_gnt", {31'b0, dbg_gnt}, 32'd0);
        chk("t5_cool_stall", {31'b0, core_stall}, 32'd0);
        chk("t5_cool_we", {31'b0, ram_we}, 32'd1);
        chk("t5_cool_addr", ram_addr, 32'h200);
        tick();
        idle_inputs();
        tick();
        chk("t5_mem_core", mem[8'h80], 32'hCAFE_0005);

        // ---- 6: async reset in the middle of a locked read ----
        dbg_req = 1; dbg_lock = 1; dbg_we = 0; dbg_addr = 32'h10;
        tick();
        tick();
        chk("t6_pre_gnt", {31'b0, dbg_gnt}, 32'd1);
        chk("t6_pre_state", {30'b0, dut.state}, {30'b0, S_DBG});
        #1 rst = 0;
        #1;
        chk("t6_gnt", {31'b0, dbg_gnt}, 32'd0);
        chk("t6_ram_ce", {31'b0, ram_ce}, 32'd0);
        chk("t6_ram_we", {31'b0, ram_we}, 32'd0);
        chk("t6_stall", {31'b0, core_stall}, 32'd0);
        chk("t6_rvalid", {31'b0, dbg_rvalid}, 32'd0);
        chk("t6_rdata", dbg_rdata, 32'd0);
        chk("t6_state", {30'b0, dut.state}, {30'b0, S_CORE});
        idle_inputs();
        @(negedge clk);
        rst = 1;
        tick();
        chk("t6_post_rvalid", {31'b0, dbg_rvalid}, 32'd0);
        // Back in S_CORE: a busy core keeps priority over a new request
        core_ce = 1; dbg_req = 1;
        #1;
        chk("t6_post_gnt", {31'b0, dbg_gnt}, 32'd0);
        tick();
        chk("t6_post_rvalid2", {31'b0, dbg_rvalid}, 32'd0);
        idle_inputs();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_dram_arbiter

`default_nettype wire
